csr_access_ctrl: RTL
====================

Name: csr_access_ctrl

Overview:
- Sequencer between the decode/issue path and the machine-mode CSR file.
- Accepts one Zicsr instruction at a time (CSRRW/RS/RC and the immediate forms) over a valid/ready handshake.
- Drives the CSR file's combinational read port, computes the read-modify-write value, then drives its write port one cycle later.
- Returns the old CSR value plus any exception to writeback over a second valid/ready handshake.

Parameters:
- XLEN, 64, data width of rs1, the CSR port and the result.
- EXC_ILLEGAL, 5'd2, exception code for an illegal instruction.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock, reset is asynchronous and active-low
- flush_i  in  1  pipeline flush; aborts the instruction in flight
- req_valid_i  in  1  CSR instruction valid
- req_ready_o  out  1  block idle, can accept
- req_funct3_i  in  3  Zicsr funct3
- req_csr_addr_i  in  12  CSR address
- req_rs1_idx_i  in  5  rs1 index / zimm
- req_rs1_data_i  in  XLEN  rs1 value
- req_rd_idx_i  in  5  destination register
- csr_rd_en_o  out  1  CSR read enable
- csr_rd_addr_o  out  12  CSR read address
- csr_rd_data_i  in  XLEN  CSR read data (combinational)
- csr_wr_en_o  out  1  CSR write enable
- csr_wr_addr_o  out  12  CSR write address
- csr_wr_data_o  out  XLEN  CSR write data
- csr_flush_o  out  1  flush_i passed through to the CSR file
- csr_exc_valid_i  in  1  CSR file access fault (combinational)
- csr_exc_code_i  in  5  CSR file fault code
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  writeback accepts
- resp_rd_idx_o  out  5  destination register
- resp_rd_we_o  out  1  register-file write required
- resp_rd_data_o  out  XLEN  old CSR value
- resp_exc_valid_o  out  1  instruction faulted
- resp_exc_code_o  out  5  fault code

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset: state IDLE. req_ready_o=1. All CSR-side enables 0. All resp_* outputs 0.
- IDLE: req_ready_o=1.
  - On req_valid_i & ~flush_i: latch the request and go to READ.
  - Illegal at acceptance (funct3 is 000 or 100, or a write is needed and csr_addr[11:10]==2'b11): go straight to RESP with exc=EXC_ILLEGAL, rd_we=0; no CSR access is issued.
- Source operand: src = funct3[2] ? zero-extended rs1_idx : rs1_data.
- Enable rules:
  - need_rd = (funct3[1:0]==01) ? (rd_idx!=0) : 1.
  - need_wr = (funct3[1:0]==01) ? 1 : (rs1_idx!=0).
- READ (one cycle):
  - csr_rd_en_o=need_rd, csr_rd_addr_o=addr.
  - Capture csr_rd_data_i into old, or 0 if ~need_rd.
  - If csr_exc_valid_i: capture the exception and go to RESP; no write is issued.
  - Otherwise go to WRITE.
- WRITE (one cycle): csr_wr_en_o=need_wr, csr_wr_addr_o=addr.
  - csr_wr_data_o: RW → src; RS → old|src; RC → old&~src.
  - If csr_exc_valid_i: capture the exception.
  - Go to RESP.
- RESP:
  - resp_valid_o=1 with resp_rd_data_o=old, resp_rd_idx_o=rd, resp_rd_we_o=(rd!=0)&~exc.
  - Hold all outputs stable until resp_ready_i, then return to IDLE. The next request can be accepted in the following cycle.
- Latency: accept in cycle 0; READ in cycle 1; WRITE in cycle 2; resp_valid in cycle 3. Latency is fixed even when need_rd or need_wr is 0. Throughput is one instruction per 4 cycles minimum.
- Enable gating: csr_rd_en_o and csr_wr_en_o are asserted only in their own state, are never both asserted, and are 0 in every cycle flush_i is 1.
- Flush: in any state, flush_i=1 forces IDLE next cycle.
  - Any pending response is dropped (resp_valid_o deasserts next cycle).
  - A write in the flush cycle is suppressed, because the CSR file gates on csr_flush_o and this block also gates csr_wr_en_o.
  - flush_i together with req_valid_i in IDLE: the request is not accepted.
- Async reset mid-operation: return to IDLE immediately; no partial write completes.

Decomposition:
- Package csr_pkg:
  - funct3 encodings: CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111.
  - EXC_ILLEGAL.
  - CSR address constants shared with the CSR file.
  - State enum type.
- Sub-modules: none. The read-modify-write ALU is a small function in the package (csr_rmw(funct3, old, src)).

Test Plan (bench instantiates this block with the real CSR file):
- CSRRW 0x340, rs1_data=0xDEAD_BEEF, rd=5 → resp 3 cycles after acceptance: rd_data=0, rd_we=1; a following CSRRS 0x340 rs1=x0 returns 0xDEAD_BEEF with csr_wr_en_o never high.
- CSRRSI 0x300 zimm=8, then CSRRCI 0x300 zimm=8 → reads return 0x1800 then 0x1808; mstatus ends at 0x1800.
- CSRRW 0xF11 rs1=x1 → no rd/wr enable pulses; resp exc_valid=1, code=2, rd_we=0. CSRRS 0xF11 rs1=x0 → rd_data=0, no exception.
- CSRRW to unimplemented 0x7C0 → exception captured in READ (code 2); csr_wr_en_o stays 0. funct3=3'b100 → exception with zero CSR traffic.
- CSRRW 0x340 with flush_i pulsed during WRITE → no resp_valid, mscratch unchanged; a new request is accepted the next cycle.
- Backpressure: resp_ready_i held low 5 cycles → resp outputs stable, req_ready_o=0 throughout; one cycle after the handshake req_ready_o=1.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: funct3 encodings, CSR addresses, sequencer states and the RMW helper.
package csr_pkg;

    localparam int CSR_XLEN = 64;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam logic [4:0] EXC_ILLEGAL = 5'd2;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MHARTID  = 12'hF11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    // CSRRW with rd=x0 must not read; CSRRS/C with rs1=x0 must not write.
    function automatic logic need_rd(input logic [2:0] funct3, input logic [4:0] rd);
        return (funct3[1:0] == 2'b01) ? (rd != 5'd0) : 1'b1;
    endfunction

    function automatic logic need_wr(input logic [2:0] funct3, input logic [4:0] rs1);
        return (funct3[1:0] == 2'b01) ? 1'b1 : (rs1 != 5'd0);
    endfunction

    function automatic logic [CSR_XLEN-1:0] csr_rmw(input logic [2:0] funct3,
                                                    input logic [CSR_XLEN-1:0] old,
                                                    input logic [CSR_XLEN-1:0] src);
        case (funct3[1:0])
            2'b01:   return src;
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_access_ctrl.sv
// Sequences one Zicsr instruction: read CSR, write RMW value a cycle later, return the old value.
// Latency: response 3 cycles after acceptance (1 for illegal, 2 for a read fault); backpressure holds RESP.
module csr_access_ctrl #(
    parameter int         XLEN        = csr_pkg::CSR_XLEN,
    parameter logic [4:0] EXC_ILLEGAL = csr_pkg::EXC_ILLEGAL
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [11:0]     req_csr_addr_i,
    input  logic [4:0]      req_rs1_idx_i,
    input  logic [XLEN-1:0] req_rs1_data_i,
    input  logic [4:0]      req_rd_idx_i,
    output logic            csr_rd_en_o,
    output logic [11:0]     csr_rd_addr_o,
    input  logic [XLEN-1:0] csr_rd_data_i,
    output logic            csr_wr_en_o,
    output logic [11:0]     csr_wr_addr_o,
    output logic [XLEN-1:0] csr_wr_data_o,
    output logic            csr_flush_o,
    input  logic            csr_exc_valid_i,
    input  logic [4:0]      csr_exc_code_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [4:0]      resp_rd_idx_o,
    output logic            resp_rd_we_o,
    output logic [XLEN-1:0] resp_rd_data_o,
    output logic            resp_exc_valid_o,
    output logic [4:0]      resp_exc_code_o
);
    import csr_pkg::*;

    state_t            state, state_nxt;
    logic [2:0]        funct3_q;
    logic [11:0]       addr_q;
    logic [4:0]        rs1_idx_q, rd_idx_q;
    logic [XLEN-1:0]   rs1_data_q, old_q, src;
    logic              exc_q;
    logic [4:0]        exc_code_q;
    logic              accept, req_illegal, nrd, nwr, in_resp;

    assign accept      = (state == ST_IDLE) && req_valid_i && !flush_i;
    // Writes to the read-only 0xC00-0xFFF block are rejected before any CSR traffic.
    assign req_illegal = (req_funct3_i[1:0] == 2'b00) ||
                         (need_wr(req_funct3_i, req_rs1_idx_i) && (req_csr_addr_i[11:10] == 2'b11));

    assign nrd = need_rd(funct3_q, rd_idx_q);
    assign nwr = need_wr(funct3_q, rs1_idx_q);
    assign src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        csr_rd_en_o = 1'b0;
        csr_wr_en_o = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (accept) state_nxt = req_illegal ? ST_RESP : ST_READ;
            end
            ST_READ: begin
                csr_rd_en_o = nrd;
                state_nxt   = csr_exc_valid_i ? ST_RESP : ST_WRITE;
            end
            ST_WRITE: begin
                csr_wr_en_o = nwr;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush_i) begin
            state_nxt   = ST_IDLE;
            csr_rd_en_o = 1'b0;
            csr_wr_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            funct3_q   <= 3'd0;
            addr_q     <= 12'd0;
            rs1_idx_q  <= 5'd0;
            rs1_data_q <= '0;
            rd_idx_q   <= 5'd0;
            old_q      <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= 5'd0;
        end else if (accept) begin
            funct3_q   <= req_funct3_i;
            addr_q     <= req_csr_addr_i;
            rs1_idx_q  <= req_rs1_idx_i;
            rs1_data_q <= req_rs1_data_i;
            rd_idx_q   <= req_rd_idx_i;
            old_q      <= '0;
            exc_q      <= req_illegal;
            exc_code_q <= req_illegal ? EXC_ILLEGAL : 5'd0;
        end else if (!flush_i && (state == ST_READ || state == ST_WRITE)) begin
            if (state == ST_READ) old_q <= nrd ? csr_rd_data_i : '0;
            if (csr_exc_valid_i) begin
                exc_q      <= 1'b1;
                exc_code_q <= csr_exc_code_i;
            end
        end
    end

    assign csr_rd_addr_o = addr_q;
    assign csr_wr_addr_o = addr_q;
    assign csr_wr_data_o = csr_rmw(funct3_q, old_q, src);
    assign csr_flush_o   = flush_i;

    assign in_resp          = (state == ST_RESP);
    assign resp_valid_o     = in_resp;
    assign resp_rd_idx_o    = in_resp ? rd_idx_q : 5'd0;
    assign resp_rd_we_o     = in_resp && (rd_idx_q != 5'd0) && !exc_q;
    assign resp_rd_data_o   = in_resp ? old_q : '0;
    assign resp_exc_valid_o = in_resp && exc_q;
    assign resp_exc_code_o  = in_resp ? exc_code_q : 5'd0;

endmodule
